// File: rtl/aqp_esp_cmd.sv
// ESP core-specific command handler: reset request pulse, keyboard matrix,
// hand-controller state and a small keyboard character FIFO for the Z80 side.
module aqp_esp_cmd #(
  parameter int KBBUF_AW     = 4,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_msg_end,
  input  logic [7:0]  spi_cmd,
  input  logic [63:0] spi_rxdata,
  output logic        reset_req,
  output logic [63:0] keys,
  output logic [7:0]  hctrl1,
  output logic [7:0]  hctrl2,
  input  logic        kbbuf_rd,
  input  logic        kbbuf_clr,
  output logic [7:0]  kbbuf_data,
  output logic        kbbuf_empty,
  output logic        kbbuf_ovf
);

  localparam int RCW   = $clog2(RESET_CYCLES + 1);
  localparam int DEPTH = 1 << KBBUF_AW;
  localparam logic [KBBUF_AW:0] DEPTH_C = {1'b1, {KBBUF_AW{1'b0}}};

  localparam logic [7:0] CMD_RESET      = 8'h01;
  localparam logic [7:0] CMD_KEYB       = 8'h10;
  localparam logic [7:0] CMD_HCTRL      = 8'h11;
  localparam logic [7:0] CMD_WRITE_KBUF = 8'h12;

  logic                load_rst_s;
  logic                load_keys_s;
  logic                load_hctrl_s;
  logic                push_req_s;
  logic                push_ok_s;
  logic                pop_ok_s;

  logic [RCW-1:0]      rst_cnt_r;
  logic [RCW-1:0]      rst_cnt_nxt_s;
  logic                reset_req_r;
  logic [63:0]         keys_r;
  logic [7:0]          hctrl1_r;
  logic [7:0]          hctrl2_r;

  logic [7:0]          kbbuf_mem_r [DEPTH];
  logic [KBBUF_AW-1:0] wr_ptr_r;
  logic [KBBUF_AW-1:0] wr_ptr_nxt_s;
  logic [KBBUF_AW-1:0] rd_ptr_r;
  logic [KBBUF_AW-1:0] rd_ptr_nxt_s;
  logic [KBBUF_AW:0]   count_r;
  logic [KBBUF_AW:0]   count_nxt_s;
  logic                ovf_r;
  logic                ovf_nxt_s;

  // Command decode, qualified by the end-of-message strobe.
  always_comb begin
    load_rst_s   = 1'b0;
    load_keys_s  = 1'b0;
    load_hctrl_s = 1'b0;
    push_req_s   = 1'b0;
    if (spi_msg_end) begin
      case (spi_cmd)
        CMD_RESET:      load_rst_s   = 1'b1;
        CMD_KEYB:       load_keys_s  = 1'b1;
        CMD_HCTRL:      load_hctrl_s = 1'b1;
        CMD_WRITE_KBUF: push_req_s   = 1'b1;
        default: ;
      endcase
    end else begin
      load_rst_s = 1'b0;
    end
  end

  // Reset pulse counter: a reload restarts the full pulse length.
  always_comb begin
    rst_cnt_nxt_s = rst_cnt_r;
    if (load_rst_s) begin
      rst_cnt_nxt_s = RCW'(RESET_CYCLES);
    end else if (rst_cnt_r != {RCW{1'b0}}) begin
      rst_cnt_nxt_s = rst_cnt_r - RCW'(1);
    end else begin
      rst_cnt_nxt_s = rst_cnt_r;
    end
  end

  // FIFO next state; clear overrides any same-cycle push or pop.
  always_comb begin
    pop_ok_s     = kbbuf_rd && (count_r != {(KBBUF_AW+1){1'b0}});
    push_ok_s    = push_req_s && ((count_r < DEPTH_C) || pop_ok_s);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ovf_nxt_s    = ovf_r;
    if (kbbuf_clr) begin
      wr_ptr_nxt_s = {KBBUF_AW{1'b0}};
      rd_ptr_nxt_s = {KBBUF_AW{1'b0}};
      count_nxt_s  = {(KBBUF_AW+1){1'b0}};
      ovf_nxt_s    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_nxt_s = wr_ptr_r + KBBUF_AW'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_nxt_s = rd_ptr_r + KBBUF_AW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_nxt_s = count_r + (KBBUF_AW+1)'(1);
        2'b01:   count_nxt_s = count_r - (KBBUF_AW+1)'(1);
        default: count_nxt_s = count_r;
      endcase
      if (push_req_s && !push_ok_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r;
      end
    end
  end

  // State registers for command results, reset pulse and FIFO control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt_r   <= {RCW{1'b0}};
      reset_req_r <= 1'b0;
      keys_r      <= {64{1'b1}};
      hctrl1_r    <= 8'hFF;
      hctrl2_r    <= 8'hFF;
      wr_ptr_r    <= {KBBUF_AW{1'b0}};
      rd_ptr_r    <= {KBBUF_AW{1'b0}};
      count_r     <= {(KBBUF_AW+1){1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      rst_cnt_r   <= rst_cnt_nxt_s;
      reset_req_r <= (rst_cnt_nxt_s != {RCW{1'b0}});
      if (load_keys_s) begin
        keys_r <= spi_rxdata;
      end
      if (load_hctrl_s) begin
        hctrl1_r <= spi_rxdata[55:48];
        hctrl2_r <= spi_rxdata[63:56];
      end
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ovf_r    <= ovf_nxt_s;
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !kbbuf_clr) begin
      kbbuf_mem_r[wr_ptr_r] <= spi_rxdata[63:56];
    end
  end

  assign reset_req   = reset_req_r;
  assign keys        = keys_r;
  assign hctrl1      = hctrl1_r;
  assign hctrl2      = hctrl2_r;
  assign kbbuf_empty = (count_r == {(KBBUF_AW+1){1'b0}});
  assign kbbuf_data  = kbbuf_empty ? 8'h00 : kbbuf_mem_r[rd_ptr_r];
  assign kbbuf_ovf   = ovf_r;

endmodule

// File: tb/tb_aqp_esp_cmd.sv
// Directed self-checking bench for aqp_esp_cmd: command decode, reset pulse
// timing, keyboard FIFO ordering/overflow/clear and asynchronous reset.
module tb_aqp_esp_cmd;

  logic        clk;
  logic        reset_n;
  logic        spi_msg_end;
  logic [7:0]  spi_cmd;
  logic [63:0] spi_rxdata;
  logic        reset_req;
  logic [63:0] keys;
  logic [7:0]  hctrl1;
  logic [7:0]  hctrl2;
  logic        kbbuf_rd;
  logic        kbbuf_clr;
  logic [7:0]  kbbuf_data;
  logic        kbbuf_empty;
  logic        kbbuf_ovf;

  int errors = 0;
  int checks = 0;
  int total;

  aqp_esp_cmd #(.KBBUF_AW(4), .RESET_CYCLES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_msg_end (spi_msg_end),
    .spi_cmd     (spi_cmd),
    .spi_rxdata  (spi_rxdata),
    .reset_req   (reset_req),
    .keys        (keys),
    .hctrl1      (hctrl1),
    .hctrl2      (hctrl2),
    .kbbuf_rd    (kbbuf_rd),
    .kbbuf_clr   (kbbuf_clr),
    .kbbuf_data  (kbbuf_data),
    .kbbuf_empty (kbbuf_empty),
    .kbbuf_ovf   (kbbuf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".reset_req"}, {63'h0, reset_req}, 64'h0);
    check({tag, ".keys"}, keys, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, ".hctrl1"}, {56'h0, hctrl1}, 64'hFF);
    check({tag, ".hctrl2"}, {56'h0, hctrl2}, 64'hFF);
    check({tag, ".kbbuf_data"}, {56'h0, kbbuf_data}, 64'h0);
    check({tag, ".kbbuf_empty"}, {63'h0, kbbuf_empty}, 64'h1);
    check({tag, ".kbbuf_ovf"}, {63'h0, kbbuf_ovf}, 64'h0);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic send(input logic [7:0] cmd, input logic [63:0] data);
    spi_cmd     = cmd;
    spi_rxdata  = data;
    spi_msg_end = 1'b1;
    @(negedge clk);
    spi_msg_end = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    send(8'h12, {b, 56'h0});
  endtask

  task automatic pop();
    kbbuf_rd = 1'b1;
    @(negedge clk);
    kbbuf_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    reset_n     = 1'b0;
    spi_msg_end = 1'b0;
    spi_cmd     = 8'h00;
    spi_rxdata  = 64'h0;
    kbbuf_rd    = 1'b0;
    kbbuf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);

    send(8'h10, 64'h0123_4567_89AB_CDEF);
    check("keys", keys, 64'h0123_4567_89AB_CDEF);
    send(8'h11, {16'hFE7F, 48'h0});
    check("hctrl2", {56'h0, hctrl2}, 64'hFE);
    check("hctrl1", {56'h0, hctrl1}, 64'h7F);
    send(8'h13, 64'h0);
    check("unknown_cmd.keys", keys, 64'h0123_4567_89AB_CDEF);
    spi_cmd    = 8'h10;
    spi_rxdata = 64'h0;
    @(negedge clk);
    check("no_strobe.keys", keys, 64'h0123_4567_89AB_CDEF);
    check("no_strobe.reset_req", {63'h0, reset_req}, 64'h0);

    // Isolated RESET pulse length
    send(8'h01, 64'h0);
    total = 0;
    while (reset_req && total < 100) begin
      total++;
      @(negedge clk);
    end
    check("rst_pulse_len", 64'(total), 64'd16);
    repeat (3) @(negedge clk);
    check("rst_pulse_idle", {63'h0, reset_req}, 64'h0);

    // Second RESET during the 10th high cycle
    send(8'h01, 64'h0);
    total = 0;
    repeat (9) begin
      if (reset_req) total++;
      @(negedge clk);
    end
    if (reset_req) total++;
    send(8'h01, 64'h0);
    while (reset_req && total < 100) begin
      total++;
      @(negedge clk);
    end
    check("rst_reload_len", 64'(total), 64'd26);

    // Basic push / pop
    push(8'h41);
    check("fifo1.data", {56'h0, kbbuf_data}, 64'h41);
    check("fifo1.empty", {63'h0, kbbuf_empty}, 64'h0);
    push(8'h42);
    push(8'h43);
    check("fifo3.data", {56'h0, kbbuf_data}, 64'h41);
    pop();
    check("pop1.data", {56'h0, kbbuf_data}, 64'h42);
    pop();
    check("pop2.data", {56'h0, kbbuf_data}, 64'h43);
    pop();
    check("pop3.data", {56'h0, kbbuf_data}, 64'h00);
    check("pop3.empty", {63'h0, kbbuf_empty}, 64'h1);
    pop();
    check("pop4.data", {56'h0, kbbuf_data}, 64'h00);
    check("pop4.empty", {63'h0, kbbuf_empty}, 64'h1);
    check("pop4.ovf", {63'h0, kbbuf_ovf}, 64'h0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      b = 8'h50 + 8'(i);
      push(b);
    end
    check("full.ovf", {63'h0, kbbuf_ovf}, 64'h0);
    push(8'h99);
    check("ovf.set", {63'h0, kbbuf_ovf}, 64'h1);
    check("ovf.head", {56'h0, kbbuf_data}, 64'h50);
    for (int i = 0; i < 16; i++) begin
      b = 8'h50 + 8'(i);
      check($sformatf("drain%0d", i), {56'h0, kbbuf_data}, {56'h0, b});
      pop();
    end
    check("drain.empty", {63'h0, kbbuf_empty}, 64'h1);
    check("drain.ovf_sticky", {63'h0, kbbuf_ovf}, 64'h1);

    kbbuf_clr = 1'b1;
    @(negedge clk);
    kbbuf_clr = 1'b0;
    check("clr.ovf", {63'h0, kbbuf_ovf}, 64'h0);

    // Push with simultaneous pop while full
    for (int i = 0; i < 16; i++) begin
      b = 8'h60 + 8'(i);
      push(b);
    end
    kbbuf_rd = 1'b1;
    send(8'h12, {8'h77, 56'h0});
    kbbuf_rd = 1'b0;
    check("pushpop.ovf", {63'h0, kbbuf_ovf}, 64'h0);
    check("pushpop.head", {56'h0, kbbuf_data}, 64'h61);
    for (int i = 0; i < 16; i++) begin
      b = (i == 15) ? 8'h77 : 8'h61 + 8'(i);
      check($sformatf("pp_drain%0d", i), {56'h0, kbbuf_data}, {56'h0, b});
      pop();
    end
    check("pp_drain.empty", {63'h0, kbbuf_empty}, 64'h1);

    // Clear coincident with push on half-full FIFO with overflow set
    for (int i = 0; i < 17; i++) begin
      b = 8'h20 + 8'(i);
      push(b);
    end
    repeat (8) pop();
    check("half.ovf", {63'h0, kbbuf_ovf}, 64'h1);
    check("half.head", {56'h0, kbbuf_data}, 64'h28);
    kbbuf_clr = 1'b1;
    kbbuf_rd  = 1'b1;
    send(8'h12, {8'hAA, 56'h0});
    kbbuf_clr = 1'b0;
    kbbuf_rd  = 1'b0;
    check("clrpush.empty", {63'h0, kbbuf_empty}, 64'h1);
    check("clrpush.ovf", {63'h0, kbbuf_ovf}, 64'h0);
    check("clrpush.data", {56'h0, kbbuf_data}, 64'h00);
    push(8'h33);
    check("after_clr.data", {56'h0, kbbuf_data}, 64'h33);

    // Asynchronous reset mid-operation
    send(8'h01, 64'h0);
    send(8'h10, 64'h0);
    check("pre_rst.reset_req", {63'h0, reset_req}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_reset("idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
